// File: rtl/buf_pingpong_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// buf_ctrl_pkg
//   Shared types for the ping-pong buffer controller.
//   exec_state_t : execute-side ownership FSM (idle / bank granted)
//   bank_t       : one-bit bank index (bank 0 / bank 1)
// ----------------------------------------------------------------------------
package buf_ctrl_pkg;

  typedef enum logic [0:0] {
    E_IDLE = 1'b0,
    E_GNT  = 1'b1
  } exec_state_t;

  typedef logic bank_t;

endpackage

// File: rtl/buf_pingpong_ctrl.sv
// ----------------------------------------------------------------------------
// buf_pingpong_ctrl
//   Sequencer for a double-buffered weight/activation buffer. A valid/ready
//   word stream is written into the current update bank; a bank that has
//   received its full fill length is marked full and handed to the execute
//   side, one bank at a time and strictly in fill order. The execute side
//   returns a bank with a single-cycle exec_done pulse.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   s_data/s_valid    : stream word in
//   s_ready           : stream word accepted when s_valid & s_ready
//   updt_len          : words per fill (0 means 2^BUF_UPDT_ADDR_WIDTH),
//                       sampled on the first beat of each fill
//   buf_updt_wr_en    : registered byte write enables to the buffer
//   buf_updt_sel      : registered bank select of the write
//   buf_updt_addr     : registered word address of the write
//   buf_updt_data     : registered write data
//   exec_req          : execute side asks for a full bank
//   exec_gnt          : a full bank is owned by the execute side
//   exec_done         : execute side finished with the granted bank
//   buf_exec_sel      : bank the execute side reads
//   bank_full         : per-bank full flags
// ----------------------------------------------------------------------------
module buf_pingpong_ctrl
  import buf_ctrl_pkg::*;
#(
  parameter int BUF_UPDT_ADDR_WIDTH = 8,
  parameter int BUF_UPDT_DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BUF_UPDT_DATA_WIDTH-1:0]   s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [BUF_UPDT_ADDR_WIDTH:0]     updt_len,
  output logic [BUF_UPDT_DATA_WIDTH/8-1:0] buf_updt_wr_en,
  output logic                             buf_updt_sel,
  output logic [BUF_UPDT_ADDR_WIDTH-1:0]   buf_updt_addr,
  output logic [BUF_UPDT_DATA_WIDTH-1:0]   buf_updt_data,
  input  logic                             exec_req,
  output logic                             exec_gnt,
  input  logic                             exec_done,
  output logic                             buf_exec_sel,
  output logic [1:0]                       bank_full
);

  localparam int AW    = BUF_UPDT_ADDR_WIDTH;
  localparam int DW    = BUF_UPDT_DATA_WIDTH;
  localparam int BE_W  = DW / 8;
  localparam int LEN_W = AW + 1;

  localparam logic [AW-1:0]    CNT_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]    CNT_ONE  = AW'(1'b1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1'b1);
  localparam logic [LEN_W-1:0] LEN_MAX  = {1'b1, {AW{1'b0}}};
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

  // Fill state
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  bank_t            wr_bank_q, wr_bank_d;

  // Bank flags
  logic [1:0]       full_q, full_d;

  // Exec FSM
  exec_state_t      state_q, state_d;
  bank_t            rd_bank_q, rd_bank_d;

  // Registered write port
  logic [BE_W-1:0]  wr_en_q, wr_en_d;
  logic             updt_sel_q, updt_sel_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;

  logic             accept_s;
  logic [LEN_W-1:0] first_len_s;
  logic [LEN_W-1:0] cur_len_s;
  logic             last_s;
  logic             done_s;

  assign s_ready  = ~rst & ~full_q[wr_bank_q];
  assign accept_s = s_valid & s_ready;

  // A zero length encodes a whole bank; the extra length bit holds 2^AW.
  assign first_len_s = (updt_len == LEN_ZERO) ? LEN_MAX : updt_len;
  // The length in force is the live input on the first beat, the latched one after.
  assign cur_len_s   = (cnt_q == CNT_ZERO) ? first_len_s : len_q;
  assign last_s      = accept_s & ({1'b0, cnt_q} == (cur_len_s - LEN_ONE));
  // exec_done only counts while a bank is actually granted.
  assign done_s      = (state_q == E_GNT) & exec_done;

  assign exec_gnt       = (state_q == E_GNT);
  assign buf_exec_sel   = rd_bank_q;
  assign bank_full      = full_q;
  assign buf_updt_wr_en = wr_en_q;
  assign buf_updt_sel   = updt_sel_q;
  assign buf_updt_addr  = addr_q;
  assign buf_updt_data  = data_q;

  // Fill counter next state: advance per accepted beat, wrap and switch bank on the last.
  always_comb begin
    cnt_d     = cnt_q;
    len_d     = len_q;
    wr_bank_d = wr_bank_q;
    if (accept_s) begin
      len_d = cur_len_s;
      if (last_s) begin
        cnt_d     = CNT_ZERO;
        wr_bank_d = ~wr_bank_q;
      end else begin
        cnt_d     = cnt_q + CNT_ONE;
        wr_bank_d = wr_bank_q;
      end
    end else begin
      cnt_d     = cnt_q;
      len_d     = len_q;
      wr_bank_d = wr_bank_q;
    end
  end

  // Bank flag next state: set and clear always hit different banks, so both apply.
  always_comb begin
    full_d = full_q;
    if (last_s) begin
      full_d[wr_bank_q] = 1'b1;
    end else begin
      full_d[wr_bank_q] = full_q[wr_bank_q];
    end
    if (done_s) begin
      full_d[rd_bank_q] = 1'b0;
    end else begin
      full_d[rd_bank_q] = full_d[rd_bank_q];
    end
  end

  // Exec FSM next state: grant the oldest full bank, release it on exec_done.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    case (state_q)
      E_IDLE: begin
        if (exec_req & full_q[rd_bank_q]) begin
          state_d = E_GNT;
        end else begin
          state_d = E_IDLE;
        end
      end
      E_GNT: begin
        if (exec_done) begin
          state_d   = E_IDLE;
          rd_bank_d = ~rd_bank_q;
        end else begin
          state_d   = E_GNT;
        end
      end
      default: begin
        state_d   = E_IDLE;
        rd_bank_d = rd_bank_q;
      end
    endcase
  end

  // Write port next state: one registered write per accepted beat, otherwise enables low.
  always_comb begin
    if (accept_s) begin
      wr_en_d    = {BE_W{1'b1}};
      updt_sel_d = wr_bank_q;
      addr_d     = cnt_q;
      data_d     = s_data;
    end else begin
      wr_en_d    = {BE_W{1'b0}};
      updt_sel_d = updt_sel_q;
      addr_d     = addr_q;
      data_d     = data_q;
    end
  end

  // Fill counter, latched length and update bank registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= CNT_ZERO;
      len_q     <= LEN_ZERO;
      wr_bank_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      wr_bank_q <= wr_bank_d;
    end
  end

  // Bank full flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 2'b00;
    end else begin
      full_q <= full_d;
    end
  end

  // Exec FSM state and read bank registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= E_IDLE;
      rd_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Buffer write port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q    <= {BE_W{1'b0}};
      updt_sel_q <= 1'b0;
      addr_q     <= CNT_ZERO;
      data_q     <= {DW{1'b0}};
    end else begin
      wr_en_q    <= wr_en_d;
      updt_sel_q <= updt_sel_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_buf_pingpong_ctrl.sv
// ----------------------------------------------------------------------------
// tb_buf_pingpong_ctrl
//   Self-checking bench for buf_pingpong_ctrl. Directed scenarios use
//   constant expectations; the random scenario is checked against a model
//   that tracks only how many fills completed and how many banks were
//   consumed, from which bank indices and flags follow arithmetically.
// ----------------------------------------------------------------------------
module tb_buf_pingpong_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [AW:0]   updt_len;
  logic [3:0]    wr_en;
  logic          updt_sel;
  logic [AW-1:0] updt_addr;
  logic [DW-1:0] updt_data;
  logic          exec_req;
  logic          exec_gnt;
  logic          exec_done;
  logic          exec_sel;
  logic [1:0]    bank_full;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  buf_pingpong_ctrl #(
    .BUF_UPDT_ADDR_WIDTH(AW),
    .BUF_UPDT_DATA_WIDTH(DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .updt_len       (updt_len),
    .buf_updt_wr_en (wr_en),
    .buf_updt_sel   (updt_sel),
    .buf_updt_addr  (updt_addr),
    .buf_updt_data  (updt_data),
    .exec_req       (exec_req),
    .exec_gnt       (exec_gnt),
    .exec_done      (exec_done),
    .buf_exec_sel   (exec_sel),
    .bank_full      (bank_full)
  );

  // ---------------- reference model ----------------
  // Fills complete into banks 0,1,0,1,...; banks are consumed in the same
  // order, so every bank index is a count modulo 2 and the number of full
  // banks is filled - consumed.
  int            m_filled, m_consumed, m_beat, m_len;
  bit            m_g;
  bit            e_wr_en;
  bit            e_sel;
  int            e_addr;
  logic [DW-1:0] e_data;

  int n_filled, n_consumed, n_beat, n_len, cur_len, m_count;
  bit n_g, n_acc;

  always_comb begin
    m_count    = m_filled - m_consumed;
    n_acc      = s_valid && !rst && (m_count < 2);
    cur_len    = (m_beat == 0) ? ((updt_len == 0) ? (1 << AW) : int'(updt_len)) : m_len;
    n_filled   = m_filled;
    n_consumed = m_consumed;
    n_beat     = m_beat;
    n_len      = m_len;
    n_g        = m_g;
    if (n_acc) begin
      n_len = cur_len;
      if (m_beat + 1 == cur_len) begin
        n_filled = m_filled + 1;
        n_beat   = 0;
      end else begin
        n_beat = m_beat + 1;
      end
    end
    if (m_g && exec_done) begin
      n_g        = 1'b0;
      n_consumed = m_consumed + 1;
    end else if (!m_g && exec_req && m_count > 0) begin
      n_g = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_filled   <= 0;
      m_consumed <= 0;
      m_beat     <= 0;
      m_len      <= 0;
      m_g        <= 1'b0;
      e_wr_en    <= 1'b0;
    end else begin
      m_filled   <= n_filled;
      m_consumed <= n_consumed;
      m_beat     <= n_beat;
      m_len      <= n_len;
      m_g        <= n_g;
      e_wr_en    <= n_acc;
      e_sel      <= (m_filled % 2) == 1;
      e_addr     <= m_beat;
      e_data     <= s_data;
    end
  end

  function automatic logic [1:0] exp_full(int f, int c);
    int k;
    k = f - c;
    if (k == 0) return 2'b00;
    else if (k == 1) return ((c % 2) == 0) ? 2'b01 : 2'b10;
    else return 2'b11;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_valid   = 1'b0;
    exec_req  = 1'b0;
    exec_done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %0h expected 0", s_ready); end
    n_checks++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL rst_wr_en: got %0h expected 0", wr_en); end
    n_checks++; if (updt_sel !== 1'b0) begin n_fail++; $display("FAIL rst_sel: got %0h expected 0", updt_sel); end
    n_checks++; if (updt_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %0h expected 0", updt_addr); end
    n_checks++; if (updt_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %0h expected 0", updt_data); end
    n_checks++; if (exec_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %0h expected 0", exec_gnt); end
    n_checks++; if (exec_sel !== 1'b0) begin n_fail++; $display("FAIL rst_exec_sel: got %0h expected 0", exec_sel); end
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL rst_bank_full: got %0h expected 0", bank_full); end
    rst = 1'b0;
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_s_ready: got %0h expected 1", s_ready); end
  endtask

  task automatic test_basic_fill();
    do_reset();
    updt_len = 9'd4;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hA0 + 32'(i);
      tick();
      n_checks++; if (wr_en !== 4'hF) begin n_fail++; $display("FAIL basic_wr_en[%0d]: got %0h expected f", i, wr_en); end
      n_checks++; if (updt_sel !== 1'b0) begin n_fail++; $display("FAIL basic_sel[%0d]: got %0h expected 0", i, updt_sel); end
      n_checks++; if (updt_addr !== 8'(i)) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0h expected %0h", i, updt_addr, i); end
      n_checks++; if (updt_data !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL basic_data[%0d]: got %0h expected %0h", i, updt_data, 32'hA0 + 32'(i)); end
      n_checks++; if (bank_full !== ((i == 3) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL basic_full[%0d]: got %0h", i, bank_full); end
    end
    s_valid = 1'b0;
    tick();
    n_checks++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL basic_idle_wr_en: got %0h expected 0", wr_en); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %0h expected 1", s_ready); end
    s_valid = 1'b1;
    s_data  = 32'hA4;
    tick();
    s_valid = 1'b0;
    n_checks++; if (updt_sel !== 1'b1) begin n_fail++; $display("FAIL basic_next_bank: got %0h expected 1", updt_sel); end
    n_checks++; if (updt_addr !== 8'h00) begin n_fail++; $display("FAIL basic_next_addr: got %0h expected 0", updt_addr); end
  endtask

  task automatic test_both_full();
    do_reset();
    updt_len = 9'd3;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hB0 + 32'(i);
      tick();
    end
    s_data = 32'hEE;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL both_ready: got %0h expected 0", s_ready); end
    n_checks++; if (bank_full !== 2'b11) begin n_fail++; $display("FAIL both_full: got %0h expected 3", bank_full); end
    exec_req = 1'b1;
    tick();
    n_checks++; if (exec_gnt !== 1'b1) begin n_fail++; $display("FAIL both_gnt: got %0h expected 1", exec_gnt); end
    n_checks++; if (exec_sel !== 1'b0) begin n_fail++; $display("FAIL both_exec_sel0: got %0h expected 0", exec_sel); end
    n_checks++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL both_blocked_wr: got %0h expected 0", wr_en); end
    exec_req  = 1'b0;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    n_checks++; if (exec_gnt !== 1'b0) begin n_fail++; $display("FAIL both_gnt_drop: got %0h expected 0", exec_gnt); end
    n_checks++; if (exec_sel !== 1'b1) begin n_fail++; $display("FAIL both_exec_sel1: got %0h expected 1", exec_sel); end
    n_checks++; if (bank_full !== 2'b10) begin n_fail++; $display("FAIL both_freed: got %0h expected 2", bank_full); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL both_ready_rise: got %0h expected 1", s_ready); end
    n_checks++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL both_no_early_wr: got %0h expected 0", wr_en); end
    s_data = 32'hB6;
    tick();
    s_valid = 1'b0;
    n_checks++; if (wr_en !== 4'hF) begin n_fail++; $display("FAIL both_refill_wr: got %0h expected f", wr_en); end
    n_checks++; if (updt_sel !== 1'b0) begin n_fail++; $display("FAIL both_refill_sel: got %0h expected 0", updt_sel); end
    n_checks++; if (updt_addr !== 8'h00) begin n_fail++; $display("FAIL both_refill_addr: got %0h expected 0", updt_addr); end
    n_checks++; if (updt_data !== 32'hB6) begin n_fail++; $display("FAIL both_refill_data: got %0h expected b6", updt_data); end
  endtask

  task automatic test_concurrent();
    do_reset();
    updt_len = 9'd2;
    s_valid  = 1'b1;
    s_data   = 32'hD0;
    tick();
    s_data   = 32'hD1;
    tick();
    exec_req = 1'b1;
    s_data   = 32'hD2;
    tick();
    n_checks++; if (exec_gnt !== 1'b1) begin n_fail++; $display("FAIL conc_gnt: got %0h expected 1", exec_gnt); end
    n_checks++; if (updt_sel !== 1'b1) begin n_fail++; $display("FAIL conc_sel: got %0h expected 1", updt_sel); end
    exec_req  = 1'b0;
    exec_done = 1'b1;
    s_data    = 32'hD3;
    tick();
    s_valid   = 1'b0;
    exec_done = 1'b0;
    n_checks++; if (bank_full !== 2'b10) begin n_fail++; $display("FAIL conc_full: got %0h expected 2", bank_full); end
    n_checks++; if (exec_gnt !== 1'b0) begin n_fail++; $display("FAIL conc_gnt_drop: got %0h expected 0", exec_gnt); end
    n_checks++; if (exec_sel !== 1'b1) begin n_fail++; $display("FAIL conc_exec_sel: got %0h expected 1", exec_sel); end
    n_checks++; if (updt_addr !== 8'h01) begin n_fail++; $display("FAIL conc_addr: got %0h expected 1", updt_addr); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL conc_ready: got %0h expected 1", s_ready); end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    n_checks++; if (bank_full !== 2'b10) begin n_fail++; $display("FAIL conc_stray_done: got %0h expected 2", bank_full); end
    n_checks++; if (exec_sel !== 1'b1) begin n_fail++; $display("FAIL conc_stray_sel: got %0h expected 1", exec_sel); end
  endtask

  task automatic test_len_zero();
    do_reset();
    updt_len = 9'd0;
    for (int i = 0; i < 256; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(i * 3);
      tick();
      n_checks++; if (updt_addr !== 8'(i) || updt_sel !== 1'b0) begin n_fail++; $display("FAIL len0_addr[%0d]: got sel %0h addr %0h", i, updt_sel, updt_addr); end
      n_checks++; if (bank_full !== ((i == 255) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL len0_full[%0d]: got %0h", i, bank_full); end
    end
    s_data = 32'h55;
    tick();
    s_valid = 1'b0;
    n_checks++; if (updt_sel !== 1'b1) begin n_fail++; $display("FAIL len0_wrap_sel: got %0h expected 1", updt_sel); end
    n_checks++; if (updt_addr !== 8'h00) begin n_fail++; $display("FAIL len0_wrap_addr: got %0h expected 0", updt_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    updt_len = 9'd4;
    s_valid  = 1'b1;
    s_data   = 32'h11;
    tick();
    s_data   = 32'h12;
    tick();
    s_valid  = 1'b0;
    rst      = 1'b1;
    tick();
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %0h expected 0", s_ready); end
    n_checks++; if (wr_en !== 4'h0 || updt_addr !== 8'h00 || updt_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_port: got en %0h addr %0h data %0h", wr_en, updt_addr, updt_data); end
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL mid_rst_full: got %0h expected 0", bank_full); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hC0 + 32'(i);
      tick();
      n_checks++; if (updt_addr !== 8'(i) || updt_sel !== 1'b0) begin n_fail++; $display("FAIL mid_refill[%0d]: got sel %0h addr %0h", i, updt_sel, updt_addr); end
      n_checks++; if (bank_full !== ((i == 3) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL mid_refill_full[%0d]: got %0h", i, bank_full); end
    end
    s_valid  = 1'b0;
    exec_req = 1'b1;
    tick();
    n_checks++; if (exec_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt: got %0h expected 1", exec_gnt); end
    exec_req = 1'b0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    n_checks++; if (exec_gnt !== 1'b0 || exec_sel !== 1'b0 || bank_full !== 2'b00) begin n_fail++; $display("FAIL mid_gnt_rst: got gnt %0h sel %0h full %0h", exec_gnt, exec_sel, bank_full); end
  endtask

  task automatic test_random();
    int cycles;
    do_reset();
    cycles = 0;
    while (m_filled < 1000 && cycles < 40000) begin
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = $urandom;
      updt_len  = ($urandom_range(0, 99) == 0) ? 9'd0 : 9'($urandom_range(1, 6));
      exec_req  = ($urandom_range(0, 1) == 1);
      exec_done = ($urandom_range(0, 3) == 0);
      tick();
      cycles++;
      n_checks++; if (s_ready !== ((m_filled - m_consumed) < 2)) begin n_fail++; $display("FAIL rnd_ready @%0d: got %0h", cycles, s_ready); end
      n_checks++; if (exec_gnt !== m_g) begin n_fail++; $display("FAIL rnd_gnt @%0d: got %0h expected %0h", cycles, exec_gnt, m_g); end
      n_checks++; if (exec_sel !== ((m_consumed % 2) == 1)) begin n_fail++; $display("FAIL rnd_exec_sel @%0d: got %0h expected %0h", cycles, exec_sel, m_consumed % 2); end
      n_checks++; if (bank_full !== exp_full(m_filled, m_consumed)) begin n_fail++; $display("FAIL rnd_full @%0d: got %0h expected %0h", cycles, bank_full, exp_full(m_filled, m_consumed)); end
      n_checks++; if (wr_en !== (e_wr_en ? 4'hF : 4'h0)) begin n_fail++; $display("FAIL rnd_wr_en @%0d: got %0h expected %0h", cycles, wr_en, e_wr_en); end
      if (e_wr_en) begin
        n_checks++; if (updt_sel !== e_sel || updt_addr !== 8'(e_addr) || updt_data !== e_data) begin n_fail++; $display("FAIL rnd_write @%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", cycles, updt_sel, updt_addr, updt_data, e_sel, e_addr, e_data); end
        if (m_g) begin
          n_checks++; if (updt_sel === exec_sel) begin n_fail++; $display("FAIL rnd_granted_bank_written @%0d: got sel %0h expected not %0h", cycles, updt_sel, exec_sel); end
        end
      end
    end
    idle_inputs();
    n_checks++; if (m_filled < 1000) begin n_fail++; $display("FAIL rnd_timeout: got %0d fills expected 1000", m_filled); end
  endtask

  initial begin
    rst      = 1'b1;
    s_data   = 32'h0;
    updt_len = 9'd1;
    idle_inputs();
    test_reset();
    test_basic_fill();
    test_both_full();
    test_concurrent();
    test_len_zero();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
